// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the demux_stream fan-out block.
package demux_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
  localparam int   CNT_W    = 16;

endpackage

// File: rtl/demux_stream_fifo.sv
// Per-channel synchronous FIFO holding {last, data}; output reads as zero when empty.
module demux_stream_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  // Extra pointer MSB distinguishes full from empty without a counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/demux_stream.sv
// Packet-atomic 1-to-NUMOUT stream demux (steered or round-robin) with per-output FIFOs.
// Optional statistics counters enabled by defining DEMUX_STREAM_STATS_EN.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter  int NUMOUT = 16,
  parameter  int DWIDTH = 14,
  parameter  int DEPTH  = 2,
  localparam int SWIDTH = $clog2(NUMOUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SWIDTH-1:0]        sel,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     din_v,
  input  logic                     din_last,
  output logic                     din_rdy,
  output logic [NUMOUT*DWIDTH-1:0] dout_vec,
  output logic [NUMOUT-1:0]        dout_vec_v,
  output logic [NUMOUT-1:0]        dout_vec_last,
  input  logic [NUMOUT-1:0]        dout_vec_rdy,
  output logic                     err
`ifdef DEMUX_STREAM_STATS_EN
  ,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [NUMOUT*CNT_W-1:0]  pkt_cnt
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [SWIDTH-1:0] dst;
  logic [SWIDTH-1:0] rr_ptr;
  logic [SWIDTH-1:0] cur_dst;
  logic              pkt_mode;
  logic              cur_mode;
  logic              rdy_en;
  logic              sel_oor;
  logic              drop_now;
  logic              tgt_full;
  logic              accept;
  logic              drop_start;
  logic [NUMOUT-1:0] push;
  logic [NUMOUT-1:0] full;
  logic [NUMOUT-1:0] empty;

  assign sel_oor    = ({1'b0, sel} >= (SWIDTH+1)'(NUMOUT));
  assign drop_start = accept && (state == IDLE) && drop_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE:        if (!din_last) state_nxt = drop_now ? DROP : ROUTE;
        ROUTE, DROP: if (din_last)  state_nxt = IDLE;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  // Destination and mode come from the inputs only on a packet's first beat.
  always_comb begin
    cur_mode = (state == IDLE) ? mode : pkt_mode;
    cur_dst  = (state == IDLE) ? ((mode == MODE_RR) ? rr_ptr : sel) : dst;
    drop_now = (state == DROP) || ((state == IDLE) && (mode == MODE_SEL) && sel_oor);
    tgt_full = 1'b0;
    for (int i = 0; i < NUMOUT; i++) begin
      if (cur_dst == SWIDTH'(i)) tgt_full = full[i];
    end
    din_rdy = rdy_en && (drop_now || !tgt_full);
    accept  = din_v && din_rdy;
    push    = '0;
    for (int i = 0; i < NUMOUT; i++) begin
      push[i] = accept && !drop_now && (cur_dst == SWIDTH'(i));
    end
  end

  // rdy_en holds the input off for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      dst      <= '0;
      pkt_mode <= MODE_SEL;
      rr_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      err    <= drop_start;
      if (accept && (state == IDLE)) begin
        dst      <= cur_dst;
        pkt_mode <= mode;
      end
      if (accept && din_last && (cur_mode == MODE_RR)) begin
        rr_ptr <= (rr_ptr == SWIDTH'(NUMOUT-1)) ? '0 : rr_ptr + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUMOUT; g++) begin : g_ch
    logic [DWIDTH:0] rdata;

    demux_stream_fifo #(
      .WIDTH(DWIDTH+1),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .wdata ({din_last, din}),
      .pop   (dout_vec_rdy[g]),
      .rdata (rdata),
      .full  (full[g]),
      .empty (empty[g])
    );

    assign dout_vec[g*DWIDTH +: DWIDTH] = rdata[DWIDTH-1:0];
    assign dout_vec_last[g]             = rdata[DWIDTH];
    assign dout_vec_v[g]                = !empty[g];
  end

`ifdef DEMUX_STREAM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                drop_cnt <= '0;
    else if (drop_start && (drop_cnt != '1))   drop_cnt <= drop_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUMOUT; g++) begin : g_stat
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (dout_vec_v[g] && dout_vec_rdy[g] && dout_vec_last[g] && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: vector table plus scoreboard, and a NUMOUT=12 instance for drops.
module tb_demux_stream;
  import demux_stream_pkg::*;

  localparam int N  = 16;
  localparam int M  = 12;
  localparam int W  = 14;
  localparam int NV = 76;

  typedef struct {
    logic         m;
    logic [3:0]   s;
    logic [W-1:0] d;
    logic         l;
    int           ch;
  } vec_t;

  typedef struct {
    int           ch;
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode, din_v, din_last, din_rdy, err;
  logic [3:0]     sel;
  logic [W-1:0]   din;
  logic [N*W-1:0] dout_vec;
  logic [N-1:0]   dout_vec_v, dout_vec_last, dout_vec_rdy;

  logic           mode12, din_v12, din_last12, din_rdy12, err12;
  logic [3:0]     sel12;
  logic [W-1:0]   din12;
  logic [M*W-1:0] dout_vec12;
  logic [M-1:0]   dout_vec_v12, dout_vec_last12, dout_vec_rdy12;

`ifdef DEMUX_STREAM_STATS_EN
  logic [CNT_W-1:0]   drop_cnt, drop_cnt12;
  logic [N*CNT_W-1:0] pkt_cnt;
  logic [M*CNT_W-1:0] pkt_cnt12;
`endif

  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   err_pulses = 0;
  bit   v12_seen = 1'b0;
  bit   lat_chk = 1'b0;
  logic [W:0] idle_or;

  demux_stream #(.NUMOUT(N), .DWIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .din(din), .din_v(din_v),
    .din_last(din_last), .din_rdy(din_rdy), .dout_vec(dout_vec), .dout_vec_v(dout_vec_v),
    .dout_vec_last(dout_vec_last), .dout_vec_rdy(dout_vec_rdy), .err(err)
`ifdef DEMUX_STREAM_STATS_EN
    , .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt)
`endif
  );

  demux_stream #(.NUMOUT(M), .DWIDTH(W), .DEPTH(2)) dut12 (
    .clk(clk), .rst_n(rst_n), .mode(mode12), .sel(sel12), .din(din12), .din_v(din_v12),
    .din_last(din_last12), .din_rdy(din_rdy12), .dout_vec(dout_vec12), .dout_vec_v(dout_vec_v12),
    .dout_vec_last(dout_vec_last12), .dout_vec_rdy(dout_vec_rdy12), .err(err12)
`ifdef DEMUX_STREAM_STATS_EN
    , .drop_cnt(drop_cnt12), .pkt_cnt(pkt_cnt12)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers one beat, waits (bounded) for acceptance, then records what the outputs must show.
  task automatic applyStimulus(input vec_t v);
    int waitc = 0;
    bit ok = 1'b0;
    mode = v.m; sel = v.s; din = v.d; din_last = v.l; din_v = 1'b1;
    while (!ok && waitc < 100) begin
      @(negedge clk);
      if (din_rdy) ok = 1'b1;
      else waitc++;
    end
    checkOutput("accept", 256'(ok), 256'(1));
    @(posedge clk); #1;
    if (ok && v.ch >= 0) begin
      sb_q.push_back('{v.ch, v.d, v.l});
      if (lat_chk) checkOutput("latency_v", 256'(dout_vec_v), 256'(16'h1 << v.ch));
    end
    din_v = 1'b0;
  endtask

  task automatic waitDrain();
    int c = 0;
    while (sb_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk); #1;
    checkOutput("drain", 256'(sb_q.size()), 256'(0));
  endtask

  // Output monitor: every output transfer must match the scoreboard head; idle lanes read zero.
  always @(negedge clk) begin
    if (rst_n) begin
      idle_or = '0;
      for (int i = 0; i < N; i++) begin
        if (dout_vec_v[i] && dout_vec_rdy[i]) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_beat", 256'({32'(i), dout_vec[i*W +: W]}), 256'(0));
          end else begin
            e = sb_q.pop_front();
            checkOutput("beat", 256'({32'(i), dout_vec[i*W +: W], dout_vec_last[i]}),
                        256'({32'(e.ch), e.d, e.l}));
          end
        end
        if (!dout_vec_v[i]) idle_or = idle_or | {dout_vec_last[i], dout_vec[i*W +: W]};
      end
      checkOutput("idle_lanes_zero", 256'(idle_or), 256'(0));
      if (err12) err_pulses++;
      if (dout_vec_v12 != '0) v12_seen = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mode = MODE_SEL; sel = '0; din = '0; din_v = 1'b0; din_last = 1'b0; dout_vec_rdy = '1;
    mode12 = MODE_SEL; sel12 = '0; din12 = '0; din_v12 = 1'b0; din_last12 = 1'b0; dout_vec_rdy12 = '1;

    for (int i = 0; i < 16; i++) vecs[i] = '{MODE_SEL, 4'(i), W'(i), 1'b1, i};
    for (int p = 0; p < 20; p++) begin
      for (int b = 0; b < 3; b++) begin
        vecs[16 + p*3 + b] = '{MODE_RR, 4'((p*7) % 16), W'(256 + p*4 + b), (b == 2), p % 16};
      end
    end

    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rst_dout_vec", 256'(dout_vec), 256'(0));
    checkOutput("rst_dout_v", 256'(dout_vec_v), 256'(0));
    checkOutput("rst_dout_last", 256'(dout_vec_last), 256'(0));
    checkOutput("rst_err", 256'(err), 256'(0));
    checkOutput("rst_din_rdy", 256'(din_rdy), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rdy_first_cycle", 256'(din_rdy), 256'(0));
    @(posedge clk); #1;
    checkOutput("rdy_second_cycle", 256'(din_rdy), 256'(1));
    checkOutput("post_rst_v", 256'(dout_vec_v), 256'(0));

    lat_chk = 1'b1;
    for (int i = 0; i < NV; i++) applyStimulus(vecs[i]);
    waitDrain();

    // Mode-0 packets above must not have moved the pointer: 20 RR packets leave it at 4.
    applyStimulus('{MODE_RR, 4'd0, W'(14'h3FF), 1'b1, 4});
    waitDrain();

    // Stall channel 5: two beats fill its FIFO, later sel changes are ignored.
    lat_chk = 1'b0;
    dout_vec_rdy = ~(16'h1 << 5);
    applyStimulus('{MODE_SEL, 4'd5, W'(14'h2A0), 1'b0, 5});
    applyStimulus('{MODE_SEL, 4'd7, W'(14'h2A1), 1'b0, 5});
    mode = MODE_SEL; sel = 4'd7; din = W'(14'h2A2); din_last = 1'b0; din_v = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_rdy", 256'(din_rdy), 256'(0));
    end
    checkOutput("stall_v", 256'(dout_vec_v), 256'(16'h0020));
    @(posedge clk); #1;
    dout_vec_rdy = '1;
    applyStimulus('{MODE_SEL, 4'd7, W'(14'h2A2), 1'b0, 5});
    applyStimulus('{MODE_SEL, 4'd7, W'(14'h2A3), 1'b1, 5});
    waitDrain();

    // Reset mid-packet with one beat queued on channel 2.
    dout_vec_rdy = ~(16'h1 << 2);
    applyStimulus('{MODE_SEL, 4'd2, W'(14'h155), 1'b0, 2});
    checkOutput("pre_rst_v", 256'(dout_vec_v), 256'(16'h0004));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_flush_v", 256'(dout_vec_v), 256'(0));
    checkOutput("rst_flush_data", 256'(dout_vec), 256'(0));
    sb_q.delete();
    dout_vec_rdy = '1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    lat_chk = 1'b1;
    applyStimulus('{MODE_SEL, 4'd2, W'(14'h0AB), 1'b0, 2});
    applyStimulus('{MODE_SEL, 4'd2, W'(14'h0AC), 1'b1, 2});
    waitDrain();

    // NUMOUT=12 instance: sel=13 packet is swallowed whole with a single err pulse.
    err_pulses = 0;
    v12_seen = 1'b0;
    mode12 = MODE_SEL; sel12 = 4'd13; din_v12 = 1'b1;
    for (int b = 0; b < 3; b++) begin
      din12 = W'(b + 1);
      din_last12 = (b == 2);
      if (b > 0) sel12 = 4'd3;
      @(negedge clk);
      checkOutput("drop_rdy", 256'(din_rdy12), 256'(1));
      @(posedge clk); #1;
      if (b == 0) checkOutput("err_pulse", 256'(err12), 256'(1));
      if (b == 1) checkOutput("err_single", 256'(err12), 256'(0));
    end
    din_v12 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_count", 256'(err_pulses), 256'(1));
    checkOutput("drop_no_valid", 256'(v12_seen), 256'(0));
`ifdef DEMUX_STREAM_STATS_EN
    checkOutput("drop_cnt", 256'(drop_cnt12), 256'(1));
`endif

    // Highest legal channel on the 12-way instance still routes normally.
    dout_vec_rdy12 = '0;
    sel12 = 4'd11; din12 = W'(14'h3C3); din_last12 = 1'b1; din_v12 = 1'b1;
    @(negedge clk);
    checkOutput("ch11_rdy", 256'(din_rdy12), 256'(1));
    @(posedge clk); #1;
    din_v12 = 1'b0;
    checkOutput("ch11_v", 256'(dout_vec_v12), 256'(12'h800));
    checkOutput("ch11_data", 256'({dout_vec_last12[11], dout_vec12[11*W +: W]}), 256'({1'b1, W'(14'h3C3)}));
    dout_vec_rdy12 = '1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
